// File: rtl/uart_mem_loader.sv
// UART byte-command interpreter that loads and inspects on-chip memory.
// Commands: SET_ADDR, SET_LEN, WRITE, READ (opcodes CMD_BASE..CMD_BASE+3).
// Each command is answered with ACK_BYTE; an unknown opcode gets NAK_BYTE.
// A 1-entry skid buffer absorbs bytes that arrive while the FSM is busy.
module uart_mem_loader #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter logic [7:0]  CMD_BASE = 8'h30,
   parameter logic [7:0]  ACK_BYTE = 8'h06,
   parameter logic [7:0]  NAK_BYTE = 8'h15
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_rx_valid,
   input  logic [7:0]          i_rx_data,
   output logic                o_tx_valid,
   input  logic                i_tx_ready,
   output logic [7:0]          o_tx_data,
   output logic                o_mem_req,
   input  logic                i_mem_gnt,
   output logic                o_mem_wen,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_strb,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   input  logic                i_mem_rvalid,
   output logic                o_busy,
   output logic                o_err_overrun
);

   localparam int unsigned NB         = DATA_W / 8;
   localparam int unsigned OFF_W      = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned ADDR_BYTES = ADDR_W / 8;

   localparam logic [7:0] OP_SET_ADDR = CMD_BASE;
   localparam logic [7:0] OP_SET_LEN  = CMD_BASE + 8'd1;
   localparam logic [7:0] OP_WRITE    = CMD_BASE + 8'd2;
   localparam logic [7:0] OP_READ     = CMD_BASE + 8'd3;

   // Clears the byte-offset bits to form a word-aligned address.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(NB - 1));
   localparam logic [OFF_W-1:0]  TOP_LANE   = OFF_W'(NB - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARG,
      S_WDATA,
      S_WMEM,
      S_RREQ,
      S_RWAIT,
      S_RSEND,
      S_RESP
   } state_t;

   // Byte lane selected by the low address bits (always 0 for 8-bit memories).
   function automatic logic [OFF_W-1:0] f_lane(input logic [ADDR_W-1:0] a);
      if (NB > 1) begin
         return a[OFF_W-1:0];
      end
      return '0;
   endfunction

   // Extract one byte lane from a memory word.
   function automatic logic [7:0] f_pick(input logic [DATA_W-1:0] d, input logic [OFF_W-1:0] lane);
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < int'(NB); k++) begin
         if (OFF_W'(k) == lane) begin
            b = d[k*8 +: 8];
         end
      end
      return b;
   endfunction

   state_t              r_state,      w_state_nxt;
   logic [ADDR_W-1:0]   r_addr,       w_addr_nxt;
   logic [31:0]         r_len,        w_len_nxt;
   logic [31:0]         r_shift,      w_shift_nxt;
   logic [2:0]          r_arg_cnt,    w_arg_cnt_nxt;
   logic                r_arg_addr,   w_arg_addr_nxt;
   logic [ADDR_W-1:0]   r_maddr,      w_maddr_nxt;
   logic [DATA_W-1:0]   r_wdata,      w_wdata_nxt;
   logic [NB-1:0]       r_strb,       w_strb_nxt;
   logic [DATA_W-1:0]   r_rdata,      w_rdata_nxt;
   logic                r_tx_valid,   w_tx_valid_nxt;
   logic [7:0]          r_tx_data,    w_tx_data_nxt;
   logic                r_skid_valid, w_skid_valid_nxt;
   logic [7:0]          r_skid_data,  w_skid_data_nxt;
   logic                r_overrun,    w_overrun_nxt;

   logic                w_can_accept;
   logic                w_byte_valid;
   logic [7:0]          w_byte;
   logic [ADDR_W-1:0]   w_addr_inc;
   logic [OFF_W-1:0]    w_lane;
   logic [OFF_W-1:0]    w_lane_inc;
   logic                w_top_lane;

   assign w_addr_inc = r_addr + ADDR_W'(1);
   assign w_lane     = f_lane(r_addr);
   assign w_lane_inc = f_lane(w_addr_inc);
   assign w_top_lane = (w_lane == TOP_LANE);

   // State and datapath registers; reset aborts any command in flight.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_len        <= '0;
         r_shift      <= '0;
         r_arg_cnt    <= '0;
         r_arg_addr   <= 1'b0;
         r_maddr      <= '0;
         r_wdata      <= '0;
         r_strb       <= '0;
         r_rdata      <= '0;
         r_tx_valid   <= 1'b0;
         r_tx_data    <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_len        <= w_len_nxt;
         r_shift      <= w_shift_nxt;
         r_arg_cnt    <= w_arg_cnt_nxt;
         r_arg_addr   <= w_arg_addr_nxt;
         r_maddr      <= w_maddr_nxt;
         r_wdata      <= w_wdata_nxt;
         r_strb       <= w_strb_nxt;
         r_rdata      <= w_rdata_nxt;
         r_tx_valid   <= w_tx_valid_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_skid_data  <= w_skid_data_nxt;
         r_overrun    <= w_overrun_nxt;
      end
   end

   // Byte intake arbitration, command decode and next-state logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_addr_nxt       = r_addr;
      w_len_nxt        = r_len;
      w_shift_nxt      = r_shift;
      w_arg_cnt_nxt    = r_arg_cnt;
      w_arg_addr_nxt   = r_arg_addr;
      w_maddr_nxt      = r_maddr;
      w_wdata_nxt      = r_wdata;
      w_strb_nxt       = r_strb;
      w_rdata_nxt      = r_rdata;
      w_tx_valid_nxt   = r_tx_valid;
      w_tx_data_nxt    = r_tx_data;
      w_skid_valid_nxt = r_skid_valid;
      w_skid_data_nxt  = r_skid_data;
      w_overrun_nxt    = r_overrun;
      w_byte_valid     = 1'b0;
      w_byte           = r_skid_valid ? r_skid_data : i_rx_data;
      w_can_accept     = (r_state == S_IDLE) || (r_state == S_ARG) || (r_state == S_WDATA);

      // The skid entry is older than a fresh rx byte, so it is consumed first
      // and the fresh byte takes its place.
      if (w_can_accept) begin
         w_byte_valid = r_skid_valid | i_rx_valid;
         if (r_skid_valid) begin
            w_skid_valid_nxt = i_rx_valid;
            if (i_rx_valid) begin
               w_skid_data_nxt = i_rx_data;
            end
         end
      end else if (i_rx_valid) begin
         if (r_skid_valid) begin
            w_overrun_nxt = 1'b1;
         end else begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = i_rx_data;
         end
      end

      unique case (r_state)
         S_IDLE: begin
            if (w_byte_valid) begin
               if (w_byte == OP_SET_ADDR) begin
                  w_arg_cnt_nxt  = 3'(ADDR_BYTES);
                  w_arg_addr_nxt = 1'b1;
                  w_state_nxt    = S_ARG;
               end else if (w_byte == OP_SET_LEN) begin
                  w_arg_cnt_nxt  = 3'd4;
                  w_arg_addr_nxt = 1'b0;
                  w_state_nxt    = S_ARG;
               end else if (w_byte == OP_WRITE) begin
                  if (r_len == 32'd0) begin
                     w_state_nxt    = S_RESP;
                     w_tx_valid_nxt = 1'b1;
                     w_tx_data_nxt  = ACK_BYTE;
                  end else begin
                     w_state_nxt = S_WDATA;
                  end
               end else if (w_byte == OP_READ) begin
                  if (r_len == 32'd0) begin
                     w_state_nxt    = S_RESP;
                     w_tx_valid_nxt = 1'b1;
                     w_tx_data_nxt  = ACK_BYTE;
                  end else begin
                     w_maddr_nxt = r_addr & ALIGN_MASK;
                     w_state_nxt = S_RREQ;
                  end
               end else begin
                  w_state_nxt    = S_RESP;
                  w_tx_valid_nxt = 1'b1;
                  w_tx_data_nxt  = NAK_BYTE;
               end
            end
         end

         S_ARG: begin
            if (w_byte_valid) begin
               w_shift_nxt   = {r_shift[23:0], w_byte};
               w_arg_cnt_nxt = r_arg_cnt - 3'd1;
               // Target register changes only once the full argument is in.
               if (r_arg_cnt == 3'd1) begin
                  if (r_arg_addr) begin
                     w_addr_nxt = w_shift_nxt[ADDR_W-1:0];
                  end else begin
                     w_len_nxt = w_shift_nxt;
                  end
                  w_state_nxt    = S_RESP;
                  w_tx_valid_nxt = 1'b1;
                  w_tx_data_nxt  = ACK_BYTE;
               end
            end
         end

         S_WDATA: begin
            if (w_byte_valid) begin
               for (int k = 0; k < int'(NB); k++) begin
                  if (OFF_W'(k) == w_lane) begin
                     w_wdata_nxt[k*8 +: 8] = w_byte;
                     w_strb_nxt[k]         = 1'b1;
                  end
               end
               // Latch the word address now; r_addr moves past it below.
               w_maddr_nxt = r_addr & ALIGN_MASK;
               w_addr_nxt  = w_addr_inc;
               w_len_nxt   = r_len - 32'd1;
               if (w_top_lane || (r_len == 32'd1)) begin
                  w_state_nxt = S_WMEM;
               end
            end
         end

         S_WMEM: begin
            if (i_mem_gnt) begin
               w_strb_nxt  = '0;
               w_wdata_nxt = '0;
               if (r_len == 32'd0) begin
                  w_state_nxt    = S_RESP;
                  w_tx_valid_nxt = 1'b1;
                  w_tx_data_nxt  = ACK_BYTE;
               end else begin
                  w_state_nxt = S_WDATA;
               end
            end
         end

         S_RREQ: begin
            if (i_mem_gnt) begin
               w_state_nxt = S_RWAIT;
            end
         end

         S_RWAIT: begin
            if (i_mem_rvalid) begin
               w_rdata_nxt    = i_mem_rdata;
               w_tx_valid_nxt = 1'b1;
               w_tx_data_nxt  = f_pick(i_mem_rdata, w_lane);
               w_state_nxt    = S_RSEND;
            end
         end

         S_RSEND: begin
            if (i_tx_ready) begin
               w_addr_nxt = w_addr_inc;
               w_len_nxt  = r_len - 32'd1;
               if (r_len == 32'd1) begin
                  w_state_nxt   = S_RESP;
                  w_tx_data_nxt = ACK_BYTE;
               end else if (w_top_lane) begin
                  w_tx_valid_nxt = 1'b0;
                  w_maddr_nxt    = w_addr_inc & ALIGN_MASK;
                  w_state_nxt    = S_RREQ;
               end else begin
                  w_tx_data_nxt = f_pick(r_rdata, w_lane_inc);
               end
            end
         end

         S_RESP: begin
            if (i_tx_ready) begin
               w_tx_valid_nxt = 1'b0;
               w_state_nxt    = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Memory request is decoded from state so an async reset drops it at once.
   assign o_mem_req     = (r_state == S_WMEM) || (r_state == S_RREQ);
   assign o_mem_wen     = (r_state == S_WMEM);
   assign o_mem_addr    = r_maddr;
   assign o_mem_wdata   = r_wdata;
   assign o_mem_strb    = r_strb;
   assign o_tx_valid    = r_tx_valid;
   assign o_tx_data     = r_tx_data;
   assign o_busy        = (r_state != S_IDLE);
   assign o_err_overrun = r_overrun;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: directed scenarios plus a random
// command stream checked against a byte-level memory/command model.
module tb_uart_mem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_strb;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_rvalid = 1'b0;
   logic        busy;
   logic        err_overrun;

   uart_mem_loader #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .CMD_BASE (8'h30),
      .ACK_BYTE (8'h06),
      .NAK_BYTE (8'h15)
   ) u_dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_rx_valid    (rx_valid),
      .i_rx_data     (rx_data),
      .o_tx_valid    (tx_valid),
      .i_tx_ready    (tx_ready),
      .o_tx_data     (tx_data),
      .o_mem_req     (mem_req),
      .i_mem_gnt     (mem_gnt),
      .o_mem_wen     (mem_wen),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .o_mem_strb    (mem_strb),
      .i_mem_rdata   (mem_rdata),
      .i_mem_rvalid  (mem_rvalid),
      .o_busy        (busy),
      .o_err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   typedef struct packed {
      logic [31:0] addr;
      logic        wen;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } mem_txn_t;

   mem_txn_t    txn_q[$];
   logic [7:0]  bmem [logic [31:0]];
   bit          gnt_hold = 1'b0;
   int unsigned gnt_pct = 100;
   int unsigned req_cycles = 0;
   int unsigned req_wait = 0;
   bit          rd_pend = 1'b0;
   int unsigned rd_cnt = 0;
   logic [31:0] rd_word = 32'h0;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : 8'h00;
   endfunction

   always @(negedge clk) begin
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b0;
      if (reset) begin
         rd_pend  = 1'b0;
         req_wait = 0;
      end else begin
         if (rd_pend) begin
            if (rd_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd_word;
               rd_pend    = 1'b0;
            end else begin
               rd_cnt--;
            end
         end
         if (mem_req) begin
            req_cycles++;
            if (!gnt_hold && (req_wait >= 3 || $urandom_range(99) < gnt_pct)) begin
               mem_gnt  = 1'b1;
               req_wait = 0;
               txn_q.push_back('{addr: mem_addr, wen: mem_wen, strb: mem_strb, wdata: mem_wdata});
               if (mem_wen) begin
                  for (int k = 0; k < 4; k++) begin
                     if (mem_strb[k]) bmem[mem_addr + 32'(k)] = mem_wdata[k*8 +: 8];
                  end
               end else begin
                  rd_word = {mem_byte(mem_addr + 32'd3), mem_byte(mem_addr + 32'd2),
                             mem_byte(mem_addr + 32'd1), mem_byte(mem_addr)};
                  rd_pend = 1'b1;
                  rd_cnt  = $urandom_range(2);
               end
            end else if (!gnt_hold) begin
               req_wait++;
            end
         end
      end
   end

   // ---------------- tx sink ----------------
   int unsigned tx_mode = 0;  // 0 always ready, 1 random, 2 hold off
   logic [7:0]  tx_q[$];
   logic [7:0]  exp_q[$];

   always @(negedge clk) begin
      if (tx_mode == 0)      tx_ready = 1'b1;
      else if (tx_mode == 1) tx_ready = ($urandom_range(99) < 60);
      else                   tx_ready = 1'b0;
      if (!reset && tx_valid && tx_ready) tx_q.push_back(tx_data);
   end

   // ---------------- reference model ----------------
   logic [7:0]  ref_mem [logic [31:0]];
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_len = 32'h0;
   logic [7:0]  data_q[$];

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_tx(input string tag);
      int unsigned t = 0;
      while (tx_q.size() < exp_q.size() && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check_val({tag, " tx count"}, 64'(tx_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < tx_q.size()) check_val({tag, " tx byte"}, tx_q[i], exp_q[i]);
      end
      tx_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_req(input string tag);
      int unsigned t = 0;
      while (!mem_req && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_val({tag, " mem_req seen"}, mem_req, 1'b1);
   endtask

   task automatic cmd_set_addr(input logic [31:0] a);
      send_byte(8'h30, 1);
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1);
      m_addr = a;
      exp_q.push_back(8'h06);
      wait_tx("set_addr");
   endtask

   task automatic cmd_set_len(input logic [31:0] l);
      send_byte(8'h31, 1);
      for (int i = 3; i >= 0; i--) send_byte(l[i*8 +: 8], 1);
      m_len = l;
      exp_q.push_back(8'h06);
      wait_tx("set_len");
   endtask

   // Sends m_len bytes taken from data_q.
   task automatic cmd_write(input string tag);
      logic [7:0] b;
      send_byte(8'h32, 2);
      for (int unsigned i = 0; i < m_len; i++) begin
         b = data_q.pop_front();
         ref_mem[m_addr] = b;
         m_addr++;
         send_byte(b, 6);
      end
      m_len = 0;
      exp_q.push_back(8'h06);
      wait_tx(tag);
   endtask

   task automatic cmd_read(input string tag);
      send_byte(8'h33, 0);
      for (int unsigned i = 0; i < m_len; i++) exp_q.push_back(ref_byte(m_addr + i));
      m_addr += m_len;
      m_len = 0;
      exp_q.push_back(8'h06);
      wait_tx(tag);
   endtask

   task automatic check_txn(input string tag, input int idx, input logic [31:0] a,
                            input logic wen, input logic [3:0] strb, input logic [31:0] wd);
      logic [31:0] mask;
      for (int k = 0; k < 4; k++) mask[k*8 +: 8] = {8{strb[k]}};
      if (idx < txn_q.size()) begin
         check_val({tag, " addr"}, txn_q[idx].addr, a);
         check_val({tag, " wen"}, txn_q[idx].wen, wen);
         if (wen) begin
            check_val({tag, " strb"}, txn_q[idx].strb, strb);
            check_val({tag, " wdata"}, txn_q[idx].wdata & mask, wd & mask);
         end
      end else begin
         check_val({tag, " missing txn"}, 64'(txn_q.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0]  b;
      int unsigned t;
      int unsigned req_snap;

      repeat (3) @(negedge clk);
      check_val("reset tx_valid", tx_valid, 1'b0);
      check_val("reset tx_data", tx_data, 8'h00);
      check_val("reset mem_req", mem_req, 1'b0);
      check_val("reset mem_wen", mem_wen, 1'b0);
      check_val("reset mem_addr", mem_addr, 32'h0);
      check_val("reset mem_strb", mem_strb, 4'h0);
      check_val("reset mem_wdata", mem_wdata, 32'h0);
      check_val("reset busy", busy, 1'b0);
      check_val("reset overrun", err_overrun, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Aligned two-word write.
      cmd_set_addr(32'h0000_1000);
      cmd_set_len(8);
      for (int i = 0; i < 8; i++) data_q.push_back(8'h11 + 8'(i));
      txn_q.delete();
      cmd_write("wr_aligned");
      check_val("wr_aligned txn count", 64'(txn_q.size()), 64'd2);
      check_txn("wr_aligned w0", 0, 32'h1000, 1'b1, 4'hF, 32'h1413_1211);
      check_txn("wr_aligned w1", 1, 32'h1004, 1'b1, 4'hF, 32'h1817_1615);

      // Unaligned three-byte write straddling a word boundary.
      cmd_set_addr(32'h0000_1003);
      cmd_set_len(3);
      data_q.push_back(8'hAA);
      data_q.push_back(8'hBB);
      data_q.push_back(8'hCC);
      txn_q.delete();
      cmd_write("wr_unaligned");
      check_val("wr_unaligned txn count", 64'(txn_q.size()), 64'd2);
      check_txn("wr_unaligned w0", 0, 32'h1000, 1'b1, 4'b1000, 32'hAA00_0000);
      check_txn("wr_unaligned w1", 1, 32'h1004, 1'b1, 4'b0011, 32'h0000_CCBB);

      // Unaligned read with a transmitter stall mid-stream.
      for (int i = 0; i < 8; i++) begin
         bmem[32'h1000 + 32'(i)]    = 8'h11 * 8'(i + 1);
         ref_mem[32'h1000 + 32'(i)] = 8'h11 * 8'(i + 1);
      end
      cmd_set_addr(32'h0000_1002);
      cmd_set_len(4);
      txn_q.delete();
      send_byte(8'h33, 0);
      exp_q = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h06};
      m_addr = 32'h1006;
      m_len = 0;
      t = 0;
      while (tx_q.size() < 1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      tx_mode = 2;
      @(negedge clk);
      t = 0;
      while (!tx_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (20) begin
         @(negedge clk);
         check_val("tx stall hold", {tx_valid, tx_data}, {1'b1, exp_q[tx_q.size()]});
      end
      tx_mode = 0;
      wait_tx("rd_stall");
      check_val("rd txn count", 64'(txn_q.size()), 64'd2);
      check_txn("rd r0", 0, 32'h1000, 1'b0, 4'h0, 32'h0);
      check_txn("rd r1", 1, 32'h1004, 1'b0, 4'h0, 32'h0);

      // Unknown opcode.
      send_byte(8'h7F, 0);
      exp_q.push_back(8'h15);
      wait_tx("nak");
      repeat (3) @(negedge clk);
      check_val("nak busy idle", busy, 1'b0);

      // Zero-length WRITE and READ issue no memory access.
      req_snap = req_cycles;
      send_byte(8'h32, 0);
      exp_q.push_back(8'h06);
      wait_tx("wr_len0");
      cmd_read("rd_len0");
      repeat (3) @(negedge clk);
      check_val("len0 no mem_req", 64'(req_cycles - req_snap), 64'd0);

      // Random command stream against the model.
      tx_mode = 1;
      gnt_pct = 50;
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(5))
            0: cmd_set_addr(32'h3000 + $urandom_range(40));
            1: cmd_set_len($urandom_range(10));
            2, 3: begin
               if ($urandom_range(3) != 0) cmd_set_len($urandom_range(10, 1));
               for (int unsigned i = 0; i < m_len; i++) data_q.push_back(8'($urandom_range(255)));
               cmd_write("rand_wr");
            end
            4: begin
               if ($urandom_range(3) != 0) cmd_set_len($urandom_range(10, 1));
               cmd_read("rand_rd");
            end
            default: begin
               b = 8'($urandom_range(255));
               while (b >= 8'h30 && b <= 8'h33) b = 8'($urandom_range(255));
               send_byte(b, 0);
               exp_q.push_back(8'h15);
               wait_tx("rand_nak");
            end
         endcase
      end
      for (int unsigned a = 32'h3000; a < 32'h3040; a++) begin
         check_val("rand mem image", mem_byte(a), ref_byte(a));
      end
      check_val("rand no overrun", err_overrun, 1'b0);

      // Overrun: hold off the grant while two extra bytes arrive.
      tx_mode = 0;
      gnt_pct = 100;
      cmd_set_addr(32'h0000_2003);
      cmd_set_len(3);
      txn_q.delete();
      gnt_hold = 1'b1;
      send_byte(8'h32, 2);
      send_byte(8'hAA, 3);
      wait_req("ovr");
      send_byte(8'hBB, 1);
      send_byte(8'hCC, 3);
      check_val("ovr flag set", err_overrun, 1'b1);
      check_val("ovr busy", busy, 1'b1);
      repeat (46) @(negedge clk);
      gnt_hold = 1'b0;
      send_byte(8'hDD, 2);
      ref_mem[32'h2003] = 8'hAA;
      ref_mem[32'h2004] = 8'hBB;
      ref_mem[32'h2005] = 8'hDD;
      m_addr = 32'h2006;
      m_len = 0;
      exp_q.push_back(8'h06);
      wait_tx("ovr");
      check_val("ovr txn count", 64'(txn_q.size()), 64'd2);
      check_txn("ovr w0", 0, 32'h2000, 1'b1, 4'b1000, 32'hAA00_0000);
      check_txn("ovr w1", 1, 32'h2004, 1'b1, 4'b0011, 32'h0000_DDBB);
      cmd_set_addr(32'h0000_2003);
      cmd_set_len(3);
      cmd_read("ovr readback");
      check_val("ovr flag sticky", err_overrun, 1'b1);

      // Reset while a write request is pending.
      cmd_set_addr(32'h0000_4000);
      cmd_set_len(1);
      txn_q.delete();
      gnt_hold = 1'b1;
      send_byte(8'h32, 2);
      send_byte(8'h5A, 2);
      wait_req("rst");
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("rst mem_req", mem_req, 1'b0);
      check_val("rst tx_valid", tx_valid, 1'b0);
      check_val("rst busy", busy, 1'b0);
      check_val("rst overrun", err_overrun, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      gnt_hold = 1'b0;
      m_addr = 32'h0;
      m_len = 0;
      repeat (3) @(negedge clk);
      check_val("rst no write", 64'(txn_q.size()), 64'd0);
      check_val("rst mem untouched", mem_byte(32'h4000), 8'h00);
      cmd_set_addr(32'h0000_4010);
      cmd_set_len(2);
      data_q.push_back(8'h5A);
      data_q.push_back(8'hA5);
      cmd_write("post_rst wr");
      cmd_set_addr(32'h0000_4010);
      cmd_set_len(2);
      cmd_read("post_rst rd");
      check_val("post_rst overrun", err_overrun, 1'b0);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Byte-command interpreter between the UART receiver/transmitter and the on-chip memory bus.
- Generalises the board bring-up load path:
  - parametrised address and data widths;
  - byte-strobed unaligned writes;
  - a memory read-back command;
  - acknowledge bytes;
  - overrun detection.
- Host streams commands over UART to preload or inspect memory before the core leaves reset.

Parameters:
ADDR_W, 32, memory byte-address width; multiple of 8, 8..32.
DATA_W, 32, memory word width in bits; 8, 16, 32 or 64.
CMD_BASE, 8'h30, opcode of SET_ADDR; other opcodes are CMD_BASE+1..+3.
ACK_BYTE, 8'h06, byte sent on command completion.
NAK_BYTE, 8'h15, byte sent for an unknown opcode.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
rx_data  in  8  received byte.
tx_valid  out  1  byte available for the UART transmitter.
tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready.
tx_data  out  8  byte to transmit.
mem_req  out  1  memory request; held until mem_gnt.
mem_gnt  in  1  request accepted this cycle.
mem_wen  out  1  1=write, 0=read.
mem_addr  out  ADDR_W  word-aligned byte address (low log2(DATA_W/8) bits zero).
mem_wdata  out  DATA_W  write data, little-endian byte lanes.
mem_strb  out  DATA_W/8  byte-lane write enables.
mem_rdata  in  DATA_W  read data.
mem_rvalid  in  1  read data valid; arrives >=1 cycle after the read gnt.
busy  out  1  high in any state other than IDLE.
err_overrun  out  1  sticky; set when a received byte is dropped.

Behaviour:
- Reset: all outputs 0; addr/len registers 0; state IDLE; skid buffer empty. An asserted reset mid-command aborts it immediately. No ack is sent and no partial memory write is issued.
- Opcodes:
  - CMD_BASE = SET_ADDR, followed by ADDR_W/8 argument bytes.
  - +1 = SET_LEN, followed by 4 argument bytes.
  - +2 = WRITE, followed by len data bytes.
  - +3 = READ, returns len bytes on tx.
- Arguments are big-endian (MSB byte first). Address and length are updated only when the last argument byte arrives.
- States:
  - IDLE: rx byte is decoded. SET_ADDR/SET_LEN -> ARG. WRITE -> WDATA. READ -> RREQ. Unknown opcode -> RESP with NAK_BYTE.
  - ARG: shift bytes in; after the final byte -> RESP with ACK_BYTE.
  - WDATA: each byte is placed in lane addr[log2(DATA_W/8)-1:0] and its strobe set; addr += 1 (wraps modulo 2^ADDR_W); len -= 1. Go to WMEM when the lane was the top lane or len reaches 0.
  - WMEM: mem_req=1, mem_wen=1. On gnt, clear strobes; if len==0 -> RESP(ACK), else -> WDATA.
  - RREQ: mem_req=1, mem_wen=0, mem_addr=addr aligned. On gnt -> RWAIT. RWAIT: capture mem_rdata on mem_rvalid -> RSEND.
  - RSEND: present the lane at the current addr offset on tx. On tx handshake: addr += 1, len -= 1. If len==0 -> RESP(ACK); else if the lane was the top lane -> RREQ; else stay.
  - RESP: tx_valid=1 with the response byte until tx_ready, then -> IDLE.
- WRITE or READ with len==0 goes directly to RESP(ACK) with no memory access.
- After a command, addr points one past the last byte and len==0. Consecutive WRITEs therefore append; SET_LEN must be reissued before each.
- Unaligned start: the first word carries only the lanes from the start offset upward. The final word carries only the lanes written.
- Received bytes:
  - rx is never stalled. A byte arriving outside IDLE/ARG/WDATA, or in the same cycle a byte is consumed, goes into a 1-entry skid buffer.
  - The skid buffer is consumed first on the next cycle the FSM can accept a byte.
  - A byte arriving while the skid buffer is full is dropped and err_overrun is set. err_overrun is cleared only by reset.
  - Bytes arriving during READ/RESP are treated as the next command.
- tx_valid/tx_data are registered and stable until the handshake. mem_req/mem_addr/mem_wdata/mem_strb are stable until gnt.

Test Plan:
- 30 00 00 10 00 -> tx 06; internal addr = 32'h0000_1000. Then 31 00 00 00 08, 32 + bytes 11..18 -> two writes: @0x1000 wdata 0x14131211 strb 4'hF, @0x1004 0x18171615 strb 4'hF; tx 06.
- Unaligned: addr 0x1003, len 3, data AA BB CC -> @0x1000 strb 4'b1000 wdata[31:24]=AA; @0x1004 strb 4'b0011 wdata[15:0]=16'hCCBB; tx 06.
- READ addr 0x1002, len 4, memory returns 0x44332211 @0x1000 and 0x88776655 @0x1004 -> two reads; tx 33 44 55 66 06. Hold tx_ready low 20 cycles mid-stream: tx_data stays stable.
- Opcode 0x7F -> tx 15, state returns to IDLE. WRITE with len 0 -> tx 06, no mem_req.
- Hold mem_gnt low 50 cycles during WRITE while rx delivers 2 more bytes -> first byte held in the skid buffer, second dropped; err_overrun=1 until reset.
- Assert reset during WMEM with mem_req high -> mem_req, tx_valid, busy = 0 the same cycle; next SET_ADDR behaves normally.
